unidade_controle_multiciclo: RTL and testbench
==============================================

// Module: unidade_controle_multiciclo
// PURPOSE
//  Multicycle MIPS control FSM: sequences the shared ULA, memory port, PC and register file over FETCH..WB steps.
//  Supports ADD/SUB/AND/OR/NOR/SLT/JR (OP=000000), LW, SW, BEQ, ADDI, J, JAL.
//  Sits between the instruction register (OP, Funct) and the multicycle datapath muxes/enables.
//  Stalls on a single-port memory via a req/ready handshake.
// PARAMETERS
//  CNT_W   32   width of retired-instruction counter instr_count
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  OP           in   6      IR[31:26]
//  Funct        in   6      IR[5:0]
//  mem_ready    in   1      memory completes current access this cycle
//  mem_req      out  1      memory access request
//  IorD         out  1      mem addr: 0=PC, 1=ULAOut
//  MemWrite     out  1      write strobe (only with mem_ready)
//  IRWrite      out  1      load IR
//  PCWrite      out  1      unconditional PC load
//  Branch       out  1      PC load if ULA Zero (datapath ANDs)
//  PCSrc        out  2      00 ULAResult, 01 ULAOut, 10 jump addr, 11 reg A
//  ULASrcA      out  1      0=PC, 1=A
//  ULASrcB      out  2      00 B, 01 const 4, 10 SignImm, 11 SignImm<<2
//  ULAControl   out  3      010 add, 110 sub, 000 and, 001 or, 011 nor, 111 slt
//  RegWrite     out  1      register file write
//  RegDst       out  2      00 rt, 01 rd, 10 $31
//  MemtoReg     out  2      00 ULAOut, 01 mem data, 10 PC
//  instr_count  out  CNT_W  retired instructions, wraps at 2^CNT_W-1 -> 0
//  illegal      out  1      sticky illegal-opcode flag (see CONFIGURATION)
// BEHAVIOUR
//  - Moore decode of state; mem_ready gates IRWrite/PCWrite in FETCH, MemWrite in MEMWR.
//  - Unlisted outputs 0 in every state. While rst=1: all outputs 0, instr_count=0, next state FETCH.
//  - FETCH: mem_req=1, IorD=0, A=0, B=01, add, PCSrc=00; if mem_ready: IRWrite=PCWrite=1 ->DECODE; else hold.
//  - DECODE: A=0, B=11, add (branch target into ULAOut). Next by OP/Funct:
//    R-ALU->REXEC, JR->JR, LW/SW->MEMADR, BEQ->BRANCH, ADDI->ADDIEX, J->JUMP, JAL->JAL, other->FETCH.
//  - MEMADR: A=1, B=10, add; ->MEMRD (LW) or MEMWR (SW).
//  - MEMRD: mem_req, IorD=1; mem_ready ->MEMWB, else hold.  MEMWB: RegWrite, RegDst=00, MemtoReg=01 ->FETCH.
//  - MEMWR: mem_req, IorD=1, MemWrite=mem_ready; mem_ready ->FETCH, else hold.
//  - REXEC: A=1, B=00, ULAControl per Funct ->ALUWB.  ALUWB: RegWrite, RegDst=01, MemtoReg=00 ->FETCH.
//  - BRANCH: A=1, B=00, sub, Branch=1, PCSrc=01 ->FETCH.
//  - ADDIEX: A=1, B=10, add ->ADDIWB.  ADDIWB: RegWrite, RegDst=00, MemtoReg=00 ->FETCH.
//  - JUMP: PCSrc=10, PCWrite ->FETCH.  JR: PCSrc=11, PCWrite ->FETCH.
//  - JAL: PCSrc=10, PCWrite, RegWrite, RegDst=10, MemtoReg=10 (PC already +4) ->FETCH.
//  - Cycles (mem_ready=1): LW 5, SW 4, R/ADDI 4, BEQ/J/JAL/JR 3; each mem stall adds 1.
//  - instr_count +1 on every transition into FETCH from a non-FETCH state; undefined-opcode NOP also counts.
//  - rst mid-instruction: abandons access (mem_req drops same cycle), no write issued, restart in FETCH.
//  - mem_ready outside FETCH/MEMRD/MEMWR: ignored.
// CONFIGURATION
//  CTRL_ILLEGAL_TRAP_EN defined: undefined OP, or OP=000000 with undefined Funct, DECODE->TRAP;
//   TRAP holds forever, all outputs 0, illegal=1, instr_count frozen; only rst exits.
//  Not defined: undefined opcode = NOP (DECODE->FETCH, counted); illegal tied 0; no TRAP state.
// TESTING
//  1 rst 2 cycles, release, mem_ready=1 -> FETCH: mem_req=1, IRWrite=PCWrite=1, instr_count=0.
//  2 ADD (OP=0,Funct=100000), mem_ready=1 -> 4 cycles, ALUWB RegWrite=1 RegDst=01, instr_count 0->1.
//  3 LW with mem_ready low 3 cycles in MEMRD -> holds MEMRD, total 8 cycles, MemtoReg=01 in MEMWB.
//  4 SW, mem_ready low 2 cycles -> MemWrite=0 while stalled, MemWrite=1 exactly one cycle.
//  5 JAL -> 3 cycles, PCSrc=10, RegDst=10, MemtoReg=10, RegWrite=1 same cycle.
//  6 OP=111111: TRAP_EN -> illegal=1 held, count frozen; else back to FETCH, count+1; rst in MEMRD -> FETCH.

Source files
------------

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle MIPS control unit: sequences the shared ULA, memory port, PC and
// register file from FETCH to write-back, stalling on a req/ready memory port.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to lock into TRAP on undefined opcodes.
module unidade_controle_multiciclo #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       OP,
    input  logic [5:0]       Funct,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             IorD,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             Branch,
    output logic [1:0]       PCSrc,
    output logic             ULASrcA,
    output logic [1:0]       ULASrcB,
    output logic [2:0]       ULAControl,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemtoReg,
    output logic [CNT_W-1:0] instr_count,
    output logic             illegal
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_JR  = 6'b001000;

    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b110;
    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_NOR = 3'b011;
    localparam logic [2:0] ULA_SLT = 3'b111;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_REXEC, S_ALUWB, S_BRANCH, S_ADDIEX, S_ADDIWB, S_JUMP,
        S_JR, S_JAL
`ifdef CTRL_ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t           r_state;
    state_t           w_next;
    state_t           w_undef;
    logic [CNT_W-1:0] r_count;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign w_undef = S_TRAP;
`else
    assign w_undef = S_FETCH;
`endif

    // Next-state selection; DECODE dispatches on OP/Funct
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  if (mem_ready) w_next = S_DECODE;
            S_DECODE: begin
                case (OP)
                    OP_RTYPE: begin
                        case (Funct)
                            FN_ADD, FN_SUB, FN_AND, FN_OR,
                            FN_NOR, FN_SLT: w_next = S_REXEC;
                            FN_JR:          w_next = S_JR;
                            default:        w_next = w_undef;
                        endcase
                    end
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_BEQ:       w_next = S_BRANCH;
                    OP_ADDI:      w_next = S_ADDIEX;
                    OP_J:         w_next = S_JUMP;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = w_undef;
                endcase
            end
            S_MEMADR: w_next = (OP == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) w_next = S_MEMWB;
            S_MEMWR:  if (mem_ready) w_next = S_FETCH;
            S_REXEC:  w_next = S_ALUWB;
            S_ADDIEX: w_next = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_ADDIWB, S_BRANCH,
            S_JUMP, S_JR, S_JAL: w_next = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
            S_TRAP:   w_next = S_TRAP;
`endif
            default:  w_next = S_FETCH;
        endcase
    end

    // State register and retired-instruction counter (counts each return to FETCH)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
            r_count <= '0;
        end else begin
            r_state <= w_next;
            if (w_next == S_FETCH && r_state != S_FETCH)
                r_count <= r_count + CNT_W'(1);
        end
    end

    // Moore output decode; reset forces every output low in the same cycle
    always_comb begin
        mem_req    = 1'b0;
        IorD       = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        PCSrc      = 2'b00;
        ULASrcA    = 1'b0;
        ULASrcB    = 2'b00;
        ULAControl = 3'b000;
        RegWrite   = 1'b0;
        RegDst     = 2'b00;
        MemtoReg   = 2'b00;
        illegal    = 1'b0;
        if (!rst) begin
            case (r_state)
                S_FETCH: begin
                    mem_req    = 1'b1;
                    ULASrcB    = 2'b01;
                    ULAControl = ULA_ADD;
                    IRWrite    = mem_ready;
                    PCWrite    = mem_ready;
                end
                S_DECODE: begin
                    ULASrcB    = 2'b11;
                    ULAControl = ULA_ADD;
                end
                S_MEMADR, S_ADDIEX: begin
                    ULASrcA    = 1'b1;
                    ULASrcB    = 2'b10;
                    ULAControl = ULA_ADD;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    IorD    = 1'b1;
                end
                S_MEMWB: begin
                    RegWrite = 1'b1;
                    MemtoReg = 2'b01;
                end
                S_MEMWR: begin
                    mem_req  = 1'b1;
                    IorD     = 1'b1;
                    MemWrite = mem_ready;
                end
                S_REXEC: begin
                    ULASrcA = 1'b1;
                    case (Funct)
                        FN_SUB:  ULAControl = ULA_SUB;
                        FN_AND:  ULAControl = ULA_AND;
                        FN_OR:   ULAControl = ULA_OR;
                        FN_NOR:  ULAControl = ULA_NOR;
                        FN_SLT:  ULAControl = ULA_SLT;
                        default: ULAControl = ULA_ADD;
                    endcase
                end
                S_ALUWB: begin
                    RegWrite = 1'b1;
                    RegDst   = 2'b01;
                end
                S_BRANCH: begin
                    ULASrcA    = 1'b1;
                    ULAControl = ULA_SUB;
                    Branch     = 1'b1;
                    PCSrc      = 2'b01;
                end
                S_ADDIWB: RegWrite = 1'b1;
                S_JUMP: begin
                    PCSrc   = 2'b10;
                    PCWrite = 1'b1;
                end
                S_JR: begin
                    PCSrc   = 2'b11;
                    PCWrite = 1'b1;
                end
                S_JAL: begin
                    PCSrc    = 2'b10;
                    PCWrite  = 1'b1;
                    RegWrite = 1'b1;
                    RegDst   = 2'b10;
                    MemtoReg = 2'b10;
                end
`ifdef CTRL_ILLEGAL_TRAP_EN
                S_TRAP: illegal = 1'b1;
`endif
                default: ;
            endcase
        end
    end

    assign instr_count = rst ? '0 : r_count;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Scoreboard bench for the multicycle control unit: per-cycle expected
// control vectors are queued as stimulus is applied and compared at negedge.
module tb_unidade_controle_multiciclo;

    localparam int unsigned CNT_W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [5:0]       OP, Funct;
    logic             mem_ready;
    logic             mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch;
    logic [1:0]       PCSrc, ULASrcB, RegDst, MemtoReg;
    logic             ULASrcA, RegWrite, illegal;
    logic [2:0]       ULAControl;
    logic [CNT_W-1:0] instr_count;

    unidade_controle_multiciclo #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .OP(OP), .Funct(Funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .PCWrite(PCWrite), .Branch(Branch), .PCSrc(PCSrc), .ULASrcA(ULASrcA),
        .ULASrcB(ULASrcB), .ULAControl(ULAControl), .RegWrite(RegWrite),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .instr_count(instr_count),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [19:0] o;
        int          c;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cnt   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    // {mem_req,IorD,MemWrite,IRWrite,PCWrite,Branch,PCSrc,ULASrcA,ULASrcB,ULAControl,RegWrite,RegDst,MemtoReg,illegal}
    function automatic logic [19:0] v(logic mreq, logic iord, logic mw, logic irw, logic pcw,
                                      logic br, logic [1:0] pcs, logic sa, logic [1:0] sb,
                                      logic [2:0] ctl, logic rw, logic [1:0] rd,
                                      logic [1:0] m2r, logic ill);
        return {mreq, iord, mw, irw, pcw, br, pcs, sa, sb, ctl, rw, rd, m2r, ill};
    endfunction

    // One clock: apply inputs, queue the expectation, compare at negedge
    task automatic cyc(input string tag, input logic r, input logic rdy,
                       input logic [19:0] e, input int ec);
        exp_t x;
        rst       = r;
        mem_ready = rdy;
        q.push_back('{tag, e, ec});
        @(negedge clk);
        x = q.pop_front();
        check({x.tag, "_ctl"}, 32'({mem_req, IorD, MemWrite, IRWrite, PCWrite, Branch, PCSrc,
                                    ULASrcA, ULASrcB, ULAControl, RegWrite, RegDst,
                                    MemtoReg, illegal}), 32'(x.o));
        check({x.tag, "_cnt"}, 32'(instr_count), 32'(x.c));
        @(posedge clk);
        #1;
    endtask

    task automatic do_rst();
        cyc("rst", 1'b1, 1'b1, 20'h0, 0);
        cnt = 0;
    endtask
    task automatic fetch(input logic rdy);
        cyc("fetch", 1'b0, rdy, v(1,0,0,rdy,rdy,0,2'b00,0,2'b01,3'b010,0,2'b00,2'b00,0), cnt);
    endtask
    task automatic decode(input logic rdy);
        cyc("decode", 1'b0, rdy, v(0,0,0,0,0,0,2'b00,0,2'b11,3'b010,0,2'b00,2'b00,0), cnt);
    endtask
    task automatic ex_imm(input string tag);
        cyc(tag, 1'b0, 1'b1, v(0,0,0,0,0,0,2'b00,1,2'b10,3'b010,0,2'b00,2'b00,0), cnt);
    endtask
    task automatic memrd(input logic rdy);
        cyc("memrd", 1'b0, rdy, v(1,1,0,0,0,0,2'b00,0,2'b00,3'b000,0,2'b00,2'b00,0), cnt);
    endtask
    task automatic memwr(input logic rdy);
        cyc("memwr", 1'b0, rdy, v(1,1,rdy,0,0,0,2'b00,0,2'b00,3'b000,0,2'b00,2'b00,0), cnt);
    endtask
    task automatic wb(input string tag, input logic [1:0] rd, input logic [1:0] m2r);
        cyc(tag, 1'b0, 1'b1, v(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,1,rd,m2r,0), cnt);
        cnt++;
    endtask
    task automatic rtype(input logic [5:0] fn, input logic [2:0] ctl);
        OP = 6'b000000; Funct = fn;
        fetch(1'b1); decode(1'b1);
        cyc("rexec", 1'b0, 1'b1, v(0,0,0,0,0,0,2'b00,1,2'b00,ctl,0,2'b00,2'b00,0), cnt);
        wb("aluwb", 2'b01, 2'b00);
    endtask
    task automatic jtype(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [19:0] e);
        OP = op; Funct = fn;
        fetch(1'b1); decode(1'b1);
        cyc(tag, 1'b0, 1'b1, e, cnt);
        cnt++;
    endtask

    initial begin
        OP = 6'b0; Funct = 6'b0; mem_ready = 1'b1; rst = 1'b1;
        @(posedge clk); #1;
        do_rst(); do_rst();

        rtype(6'b100000, 3'b010);                      // ADD
        OP = 6'b000000; Funct = 6'b100010;             // SUB with fetch stall and ignored ready
        fetch(1'b0); fetch(1'b1); decode(1'b0);
        cyc("rexec_sub", 1'b0, 1'b1, v(0,0,0,0,0,0,2'b00,1,2'b00,3'b110,0,2'b00,2'b00,0), cnt);
        wb("aluwb", 2'b01, 2'b00);
        rtype(6'b100100, 3'b000);                      // AND
        rtype(6'b100111, 3'b011);                      // NOR
        rtype(6'b101010, 3'b111);                      // SLT

        OP = 6'b100011; Funct = 6'b0;                  // LW, 3 stall cycles
        fetch(1'b1); decode(1'b1); ex_imm("memadr");
        memrd(1'b0); memrd(1'b0); memrd(1'b0); memrd(1'b1);
        wb("memwb", 2'b00, 2'b01);

        OP = 6'b101011;                                // SW, 2 stall cycles
        fetch(1'b1); decode(1'b1); ex_imm("memadr");
        memwr(1'b0); memwr(1'b0); memwr(1'b1);
        cnt++;

        jtype("jal", 6'b000011, 6'b0, v(0,0,0,0,1,0,2'b10,0,2'b00,3'b000,1,2'b10,2'b10,0));
        jtype("beq", 6'b000100, 6'b0, v(0,0,0,0,0,1,2'b01,1,2'b00,3'b110,0,2'b00,2'b00,0));
        jtype("j",   6'b000010, 6'b0, v(0,0,0,0,1,0,2'b10,0,2'b00,3'b000,0,2'b00,2'b00,0));
        jtype("jr",  6'b000000, 6'b001000, v(0,0,0,0,1,0,2'b11,0,2'b00,3'b000,0,2'b00,2'b00,0));

        OP = 6'b001000;                                // ADDI
        fetch(1'b1); decode(1'b1); ex_imm("addiex");
        wb("addiwb", 2'b00, 2'b00);

        OP = 6'b111111;                                // undefined opcode
        fetch(1'b1); decode(1'b1);
`ifdef CTRL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 3; i++)
            cyc("trap", 1'b0, 1'b1, v(0,0,0,0,0,0,2'b00,0,2'b00,3'b000,0,2'b00,2'b00,1), cnt);
        do_rst();
`else
        cnt++;
        fetch(1'b1);
        cnt = cnt;
        OP = 6'b000000; Funct = 6'b100101;             // OR after the NOP
        decode(1'b1);
        cyc("rexec_or", 1'b0, 1'b1, v(0,0,0,0,0,0,2'b00,1,2'b00,3'b001,0,2'b00,2'b00,0), cnt);
        wb("aluwb", 2'b01, 2'b00);
`endif

        OP = 6'b100011;                                // reset while stalled in MEMRD
        fetch(1'b1); decode(1'b1); ex_imm("memadr"); memrd(1'b0);
        do_rst();
        rtype(6'b100000, 3'b010);
        fetch(1'b1);

        if (q.size() != 0) check("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
